// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional first-word-fall-through.
module sync_fifo_flags #(
  parameter int DATO_WIDTH  = 8,
  parameter int FIFO_LENGTH = 4,
  parameter int AF_LEVEL    = (1 << FIFO_LENGTH) - 2,
  parameter int AE_LEVEL    = 2,
  parameter bit FWFT        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATO_WIDTH-1:0]  datin,
  input  logic                   rd_en,
  input  logic                   flush,
  input  logic                   clr_err,
  output logic [DATO_WIDTH-1:0]  datout,
  output logic                   dato,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [FIFO_LENGTH:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int D = 1 << FIFO_LENGTH;
  localparam logic [FIFO_LENGTH:0]   DEPTH   = (FIFO_LENGTH+1)'(D);
  localparam logic [FIFO_LENGTH:0]   AF_CNT  = (FIFO_LENGTH+1)'(AF_LEVEL);
  localparam logic [FIFO_LENGTH:0]   AE_CNT  = (FIFO_LENGTH+1)'(AE_LEVEL);
  localparam logic [FIFO_LENGTH:0]   CNT_ONE = (FIFO_LENGTH+1)'(1);
  localparam logic [FIFO_LENGTH-1:0] PTR_ONE = FIFO_LENGTH'(1);

  logic [DATO_WIDTH-1:0]  mem [D];
  logic [FIFO_LENGTH-1:0] wr_ptr;
  logic [FIFO_LENGTH-1:0] rd_ptr;
  logic                   pop_ok;
  logic                   push_ok;
  logic                   pop_acc;
  logic                   push_acc;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign pop_ok   = rd_en & (count != '0);
  assign push_ok  = wr_en & ((count != DEPTH) | pop_ok);
  assign pop_acc  = pop_ok & ~flush;
  assign push_acc = push_ok & ~flush;

  assign full         = (count == DEPTH);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wr_ptr] <= datin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Clear is applied first so a same-cycle set takes priority; flushed requests never flag errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (wr_en & ~push_ok & ~flush)
        overflow <= 1'b1;
      if (rd_en & ~pop_ok & ~flush)
        underflow <= 1'b1;
    end
  end

  generate
    if (FWFT == 1'b0) begin : g_std
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          datout <= '0;
          dato   <= 1'b0;
        end else if (flush) begin
          dato <= 1'b0;
        end else if (pop_acc) begin
          datout <= mem[rd_ptr];
          dato   <= 1'b1;
        end else begin
          dato <= 1'b0;
        end
      end
    end else begin : g_fwft
      // Head word is shown directly; forced to zero while empty so reset state is defined.
      always_comb begin
        datout = '0;
        if (count != '0)
          datout = mem[rd_ptr];
        dato = (count != '0);
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: directed scenarios plus a randomized run compared
// against a queue-based reference model; a second instance covers FWFT mode.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en, flush, clr_err;
  logic [7:0] datin;
  logic [7:0] datout;
  logic       dato, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en, f_rd_en;
  logic [7:0] f_datin;
  logic [7:0] f_datout;
  logic       f_dato, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  int passed = 0;
  int total  = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_dato;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATO_WIDTH(8), .FIFO_LENGTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .datin(datin), .rd_en(rd_en), .flush(flush),
    .clr_err(clr_err), .datout(datout), .dato(dato), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.DATO_WIDTH(8), .FIFO_LENGTH(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .datin(f_datin), .rd_en(f_rd_en), .flush(1'b0),
    .clr_err(1'b0), .datout(f_datout), .dato(f_dato), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dato = 1'b0;
    m_dout = 8'h00;
  endtask

  // Behavioural reference: pop first (frees a slot), then push; flush discards everything.
  task automatic model_step(input bit w, input logic [7:0] d, input bit r, input bit fl, input bit ce);
    bit pop, push;
    if (ce) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (fl) begin
      q.delete();
      m_dato = 1'b0;
    end else begin
      pop  = r && (q.size() > 0);
      push = w && (q.size() < 16 || pop);
      m_dato = pop;
      if (pop) m_dout = q.pop_front();
      if (push) q.push_back(d);
      if (w && !push) m_ovf = 1'b1;
      if (r && !pop) m_unf = 1'b1;
    end
  endtask

  task automatic tick(input bit w, input logic [7:0] d, input bit r, input bit fl, input bit ce);
    wr_en = w; datin = d; rd_en = r; flush = fl; clr_err = ce;
    @(posedge clk);
    model_step(w, d, r, fl, ce);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; datin = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    total++; if (count !== 5'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", empty); else passed++;
    total++; if (full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", full); else passed++;
    total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0)
      $display("[TB] FAIL reset_almost: got ae=%b af=%b expected ae=1 af=0", almost_empty, almost_full); else passed++;
    total++; if (dato !== 1'b0 || datout !== 8'h00)
      $display("[TB] FAIL reset_data: got dato=%b datout=%h expected 0/00", dato, datout); else passed++;
    total++; if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("[TB] FAIL reset_err: got ovf=%b unf=%b expected 0/0", overflow, underflow); else passed++;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 16; i++) tick(1, 8'(i), 0, 0, 0);
    tick(1, 8'hAA, 0, 0, 0);
    total++; if (full !== 1'b1 || count !== 5'd16)
      $display("[TB] FAIL ovf_full: got full=%b count=%0d expected 1/16", full, count); else passed++;
    total++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); else passed++;
    for (int i = 1; i <= 16; i++) begin
      tick(0, 0, 1, 0, 0);
      total++; if (datout !== 8'(i) || dato !== 1'b1)
        $display("[TB] FAIL ovf_pop%0d: got %h/%b expected %h/1", i, datout, dato, 8'(i)); else passed++;
    end
    tick(0, 0, 0, 0, 0);
    total++; if (dato !== 1'b0 || empty !== 1'b1)
      $display("[TB] FAIL ovf_drained: got dato=%b empty=%b expected 0/1", dato, empty); else passed++;
  endtask

  task automatic test_underflow();
    apply_reset();
    tick(0, 0, 1, 0, 0);
    total++; if (underflow !== 1'b1 || dato !== 1'b0 || count !== 5'd0)
      $display("[TB] FAIL unf_set: got unf=%b dato=%b count=%0d expected 1/0/0", underflow, dato, count); else passed++;
    tick(0, 0, 0, 0, 1);
    total++; if (underflow !== 1'b0) $display("[TB] FAIL unf_clear: got %b expected 0", underflow); else passed++;
    tick(0, 0, 1, 0, 1);
    total++; if (underflow !== 1'b1)
      $display("[TB] FAIL unf_set_wins: got %b expected 1", underflow); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] last;
    apply_reset();
    for (int i = 1; i <= 16; i++) tick(1, 8'(i), 0, 0, 0);
    tick(1, 8'h55, 1, 0, 0);
    total++; if (count !== 5'd16 || full !== 1'b1)
      $display("[TB] FAIL b2b_count: got count=%0d full=%b expected 16/1", count, full); else passed++;
    total++; if (datout !== 8'h01 || overflow !== 1'b0)
      $display("[TB] FAIL b2b_data: got datout=%h ovf=%b expected 01/0", datout, overflow); else passed++;
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 1, 0, 0);
      last = datout;
    end
    total++; if (last !== 8'h55) $display("[TB] FAIL b2b_last: got %h expected 55", last); else passed++;
  endtask

  task automatic test_thresholds();
    apply_reset();
    tick(1, 8'h11, 0, 0, 0);
    tick(1, 8'h12, 0, 0, 0);
    total++; if (almost_empty !== 1'b1) $display("[TB] FAIL ae_at2: got %b expected 1", almost_empty); else passed++;
    tick(1, 8'h13, 0, 0, 0);
    total++; if (almost_empty !== 1'b0) $display("[TB] FAIL ae_at3: got %b expected 0", almost_empty); else passed++;
    for (int i = 4; i <= 13; i++) tick(1, 8'(i), 0, 0, 0);
    total++; if (almost_full !== 1'b0) $display("[TB] FAIL af_at13: got %b expected 0", almost_full); else passed++;
    tick(1, 8'h0E, 0, 0, 0);
    total++; if (almost_full !== 1'b1 || count !== 5'd14)
      $display("[TB] FAIL af_at14: got af=%b count=%0d expected 1/14", almost_full, count); else passed++;
    tick(0, 0, 1, 0, 0);
    total++; if (almost_full !== 1'b0) $display("[TB] FAIL af_after_pop: got %b expected 0", almost_full); else passed++;
  endtask

  task automatic test_random_wrap();
    bit w, r, fl, ce;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      w  = ($urandom_range(99) < ((c < 200) ? 65 : 35));
      r  = ($urandom_range(99) < ((c < 200) ? 35 : 65));
      fl = ($urandom_range(59) == 0);
      ce = ($urandom_range(29) == 0);
      tick(w, 8'($urandom), r, fl, ce);
      total++; if (count !== 5'(q.size()))
        $display("[TB] FAIL rnd_count c%0d: got %0d expected %0d", c, count, q.size()); else passed++;
      total++; if (full !== (q.size() == 16) || empty !== (q.size() == 0))
        $display("[TB] FAIL rnd_fe c%0d: got full=%b empty=%b size=%0d", c, full, empty, q.size()); else passed++;
      total++; if (almost_full !== (q.size() >= 14) || almost_empty !== (q.size() <= 2))
        $display("[TB] FAIL rnd_almost c%0d: got af=%b ae=%b size=%0d", c, almost_full, almost_empty, q.size()); else passed++;
      total++; if (dato !== m_dato || datout !== m_dout)
        $display("[TB] FAIL rnd_data c%0d: got %h/%b expected %h/%b", c, datout, dato, m_dout, m_dato); else passed++;
      total++; if (overflow !== m_ovf || underflow !== m_unf)
        $display("[TB] FAIL rnd_err c%0d: got %b/%b expected %b/%b", c, overflow, underflow, m_ovf, m_unf); else passed++;
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      tick(0, 0, 1, 0, 0);
      total++; if (datout !== m_dout)
        $display("[TB] FAIL rnd_drain%0d: got %h expected %h", i, datout, m_dout); else passed++;
    end
    total++; if (count !== 5'd0) $display("[TB] FAIL rnd_final_count: got %0d expected 0", count); else passed++;
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 1; i <= 16; i++) tick(1, 8'(i), 0, 0, 0);
    tick(1, 8'hAA, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, 0, 0);
    total++; if (count !== 5'd7) $display("[TB] FAIL flush_pre: got %0d expected 7", count); else passed++;
    tick(1, 8'h99, 1, 1, 0);
    total++; if (count !== 5'd0 || empty !== 1'b1)
      $display("[TB] FAIL flush_count: got count=%0d empty=%b expected 0/1", count, empty); else passed++;
    total++; if (overflow !== 1'b1 || dato !== 1'b0 || datout !== 8'h09)
      $display("[TB] FAIL flush_hold: got ovf=%b dato=%b datout=%h expected 1/0/09", overflow, dato, datout); else passed++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    tick(1, 8'h91, 0, 0, 0);
    tick(1, 8'h92, 0, 0, 0);
    tick(1, 8'h93, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0)
      $display("[TB] FAIL arst_count: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); else passed++;
    total++; if (datout !== 8'h00 || dato !== 1'b0)
      $display("[TB] FAIL arst_data: got %h/%b expected 00/0", datout, dato); else passed++;
    @(negedge clk);
    rst = 1'b1;
    tick(1, 8'h77, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    total++; if (datout !== 8'h77 || dato !== 1'b1)
      $display("[TB] FAIL arst_first: got %h/%b expected 77/1", datout, dato); else passed++;
  endtask

  task automatic test_fwft();
    apply_reset();
    total++; if (f_empty !== 1'b1 || f_dato !== 1'b0)
      $display("[TB] FAIL fwft_idle: got empty=%b dato=%b expected 1/0", f_empty, f_dato); else passed++;
    f_wr_en = 1; f_datin = 8'h3C;
    @(posedge clk); #1;
    f_wr_en = 0;
    total++; if (f_datout !== 8'h3C || f_dato !== 1'b1)
      $display("[TB] FAIL fwft_show: got %h/%b expected 3C/1", f_datout, f_dato); else passed++;
    f_rd_en = 1;
    @(posedge clk); #1;
    f_rd_en = 0;
    total++; if (f_empty !== 1'b1 || f_dato !== 1'b0)
      $display("[TB] FAIL fwft_pop: got empty=%b dato=%b expected 1/0", f_empty, f_dato); else passed++;
    f_wr_en = 1; f_datin = 8'hA1;
    @(posedge clk); #1;
    f_datin = 8'hB2;
    @(posedge clk); #1;
    f_wr_en = 0;
    total++; if (f_datout !== 8'hA1 || f_count !== 5'd2)
      $display("[TB] FAIL fwft_head: got %h count=%0d expected A1/2", f_datout, f_count); else passed++;
    f_rd_en = 1;
    @(posedge clk); #1;
    f_rd_en = 0;
    total++; if (f_datout !== 8'hB2 || f_dato !== 1'b1)
      $display("[TB] FAIL fwft_next: got %h/%b expected B2/1", f_datout, f_dato); else passed++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; datin = 0;
    f_wr_en = 0; f_rd_en = 0; f_datin = 0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_thresholds();
    test_random_wrap();
    test_flush();
    test_async_reset();
    test_fwft();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO that replaces the earlier dual-strobe FIFO in the LM32 peripheral datapath, e.g. command/move queues between the wishbone slave and the motor sequencers.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush and a selectable read mode (standard or first-word-fall-through).
- All state is edge-triggered on one clock; no strobe-derived clocks.

Parameters:
- DATO_WIDTH, 8, data word width in bits (>=1).
- FIFO_LENGTH, 4, log2 of depth; depth D = 2^FIFO_LENGTH (FIFO_LENGTH >= 1).
- AF_LEVEL, D-2, almost_full asserted when count >= AF_LEVEL (1..D).
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..D-1).
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  push request.
- datin  in  DATO_WIDTH  write data, sampled with wr_en.
- rd_en  in  1  pop request.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  synchronous clear of overflow/underflow.
- datout  out  DATO_WIDTH  read data.
- dato  out  1  datout valid.
- full  out  1  count == D.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  FIFO_LENGTH+1  current occupancy, 0..D.
- overflow  out  1  sticky: rejected push seen.
- underflow  out  1  sticky: rejected pop seen.

Behaviour:
- Reset (rst=0, asynchronous): pointers, count, datout, dato, overflow and underflow are 0. empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0). Memory contents are not cleared.
- Storage: D-entry array. wr_ptr and rd_ptr are FIFO_LENGTH bits wide and wrap naturally from D-1 to 0. count is a separate register; full/empty are not derived from pointer equality.
- pop_ok = rd_en & (count != 0).
- push_ok = wr_en & ((count != D) | pop_ok): a push into a full FIFO succeeds only when a pop is accepted in the same cycle.
- Simultaneous push_ok & pop_ok: count unchanged, both pointers advance. On empty, the pop is rejected and only the push happens, so no write-through bypass.
- Count update: count_next = count + push_ok - pop_ok.
- Flags: all flags are combinational decodes of the registered count, so they change one cycle after the causing edge.
- Standard mode (FWFT=0):
  - On pop_ok, datout <= mem[rd_ptr] at that edge. dato pulses 1 for exactly the following cycle.
  - datout holds its value otherwise.
  - Read latency is 1 clock from rd_en sampled.
- FWFT mode (FWFT=1):
  - datout = mem[rd_ptr] whenever count != 0; dato = ~empty.
  - rd_en acknowledges the word currently shown.
  - The first word written into an empty FIFO appears on datout the cycle after the write edge.
- overflow: set on wr_en & ~push_ok.
- underflow: set on rd_en & ~pop_ok.
- Both error flags hold until clr_err=1 or reset. If set and clear coincide in one cycle, set wins.
- flush=1: pointers and count go to 0 and dato to 0 at that edge. Any push/pop in the same cycle is ignored and does not set error flags. flush does not clear overflow/underflow. datout holds its last value in standard mode.
- Reset asserted mid-operation: immediate return to reset values regardless of clk. The first push after deassertion lands at address 0.

Test Plan (defaults: D=16, AF_LEVEL=14, AE_LEVEL=2, DATO_WIDTH=8):
- Push 0x01..0x10 (16 writes), then 1 more push 0xAA -> full=1, count=16, overflow=1. Following pops return 0x01..0x10 in order; 0xAA is never returned.
- From reset, pop with empty -> underflow=1, dato stays 0, count=0. Then clr_err=1 for one cycle -> underflow=0.
- Fill to 16, then wr_en=rd_en=1 with datin=0x55 -> count stays 16, full stays 1, datout=0x01 next cycle, no overflow. After 16 further pops, 0x55 is the last word returned.
- Push 3 words -> almost_empty 1->0 as count goes 2->3. Push up to count=14 -> almost_full=1. Pop 1 -> almost_full=0 one cycle later.
- Push 20 words and pop 20 words interleaved, so pointers wrap past 15 -> data order preserved with no loss or duplication, and count returns to 0.
- FWFT=1 build: push 0x3C into empty -> next cycle datout=0x3C, dato=1. rd_en=1 -> next cycle empty=1, dato=0.
- flush=1 with count=7 and wr_en=1 -> count=0, empty=1, overflow unchanged. Assert rst=0 between clock edges -> all outputs return to reset values immediately.
